pupil_locator: RTL and testbench
================================

# pupil_locator

Consumes the windowed grayscale pixel stream (valid strobe, 10-bit gray, H/V counters, frame valid) and locates the dark pupil region. Pixels below a darkness threshold inside the active column window are accumulated per frame. At end of frame a serial restoring divider computes the centroid. The block sits downstream of the grayscale/window stage and feeds the overlay and tracking logic with one coordinate pair per frame.

## Interface
- H_MIN, 255: column window lower bound, exclusive.
- H_MAX, 640: column window upper bound, exclusive.
- THRESH, 200: a pixel is dark when gray < THRESH.
- CNT_W, 22: width of the dark-pixel counter.
- SUM_W, 35: width of the coordinate accumulators and divider dividend; must be ≥ 13 + CNT_W.

- iCLK  in  1  clock; all logic on rising edge.
- iRST  in  1  synchronous reset, active-high.
- iDVAL  in  1  pixel valid.
- iFVAL  in  1  frame valid; its falling edge marks end of frame.
- iGRAY  in  10  grayscale pixel.
- iH_Cont  in  13  column of the current pixel.
- iV_Cont  in  13  row of the current pixel.
- oX  out  13  centroid column.
- oY  out  13  centroid row.
- oCOUNT  out  CNT_W  dark-pixel count of the reported frame.
- oFOUND  out  1  reported frame contained ≥1 dark pixel.
- oVALID  out  1  one-cycle pulse: oX/oY/oCOUNT/oFOUND updated.
- oBUSY  out  1  divider running.
- oDROP  out  1  one-cycle pulse: a frame ended while the divider was busy.

## Operation
- Accept condition, all on the same cycle:
  - iDVAL=1 and iFVAL=1;
  - H_MIN < iH_Cont < H_MAX;
  - iGRAY < THRESH.
- On accept:
  - sum_x += iH_Cont and sum_y += iV_Cont, both zero-extended to SUM_W;
  - cnt += 1, saturating at all-ones.
- fval_d is iFVAL registered. End of frame (EOF) is fval_d=1 and iFVAL=0.
- At EOF:
  - the accumulators are snapshotted into divider registers and cleared on the same edge;
  - a pixel accepted on the EOF cycle is dropped; it cannot occur, because iFVAL=0.
- Accumulation runs independently of the divider. The next frame accumulates while division proceeds.
- FSM states: IDLE, DIV_X, DIV_Y, DONE.
  - IDLE → DIV_X at EOF when cnt≠0.
  - IDLE → DONE at EOF when cnt=0; oFOUND=0, and oX/oY hold their previous values.
  - DIV_X → DIV_Y after SUM_W iterations.
  - DIV_Y → DONE after SUM_W iterations.
  - DONE → IDLE after one cycle.
- Divider: restoring, one quotient bit per cycle, MSB first, divisor = cnt snapshot.
  - The quotient is truncated toward zero.
  - The low 13 bits go to oX/oY. The quotient always fits, because mean ≤ max coordinate.
- EOF while state≠IDLE: the new frame's accumulators are still cleared, its result is discarded, and oDROP pulses. The in-flight division is unaffected.
- oBUSY=1 in DIV_X and DIV_Y.

## Timing
- Reset values:
  - oX, oY, oCOUNT are 0; oFOUND, oVALID, oBUSY, oDROP are 0;
  - sum_x, sum_y, cnt, fval_d are 0; state is IDLE.
- Reset mid-division aborts the division with no oVALID. The first cycle after reset is IDLE.
- Let E0 be the rising edge that samples EOF.
- Non-empty frame:
  - state is DIV_X from E0 and DIV_Y from E0+SUM_W;
  - DONE on edge E0+2·SUM_W;
  - outputs and oVALID=1 on edge E0+2·SUM_W+1. With defaults, oVALID is high 71 cycles after E0.
- Empty frame: DONE at E0; oVALID=1 with oFOUND=0 and oCOUNT=0 on edge E0+1.
- oVALID is high exactly one cycle. oX/oY/oCOUNT/oFOUND are stable until the next oVALID.
- oDROP is high for the one cycle after E0 when E0 is sampled in a non-IDLE state.
- Throughput: one result per frame. Frame blanking must be ≥ 2·SUM_W+2 cycles, or frames are dropped.

## Test plan
- Single dark pixel, gray=50 at (300,100), then EOF → after 71 cycles oVALID=1, oX=300, oY=100, oCOUNT=1, oFOUND=1.
- Dark pixels at (300,100), (302,100), (300,104), (303,104) → oX=301 (1205/4 truncated), oY=102, oCOUNT=4.
- Pixels at h=255, h=640, and (400,50) with gray=200, plus a frame of all gray=1023 → all rejected; oVALID one cycle after E0, oFOUND=0, oCOUNT=0, oX/oY unchanged from the prior frame.
- Rejected pixels with iDVAL=0 or iFVAL=0 mixed with dark pixels at (260,10) and (638,20) → oX=449, oY=15, oCOUNT=2.
- A second short frame whose EOF arrives 30 cycles after E0 → oDROP pulse at E0+31. The first result is reported correctly at E0+71. A third frame reports only its own pixels.
- iRST=1 at E0+40 for one cycle → no oVALID, all outputs 0. A following frame with a dark pixel at (500,300) → oX=500, oY=300.

Source files
------------

// File: rtl/pupil_locator.sv
// pupil_locator: accumulates dark pixels inside the column window each frame and
// reports their centroid through a serial restoring divider at end of frame.
module pupil_locator #(
    parameter int H_MIN  = 255,
    parameter int H_MAX  = 640,
    parameter int THRESH = 200,
    parameter int CNT_W  = 22,
    parameter int SUM_W  = 35
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iDVAL,
    input  logic             iFVAL,
    input  logic [9:0]       iGRAY,
    input  logic [12:0]      iH_Cont,
    input  logic [12:0]      iV_Cont,
    output logic [12:0]      oX,
    output logic [12:0]      oY,
    output logic [CNT_W-1:0] oCOUNT,
    output logic             oFOUND,
    output logic             oVALID,
    output logic             oBUSY,
    output logic             oDROP
);
    localparam int IT_W = $clog2(SUM_W);

    typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, DONE} state_t;
    state_t state, nextState;

    logic             fvalD, eof, accept, lastIter, qBit;
    logic [SUM_W-1:0] sumX, sumY, divX, divY;
    logic [CNT_W-1:0] cnt, divisor, rem, remNext;
    logic [CNT_W:0]   remShift;
    logic [IT_W-1:0]  iter;

    assign eof    = fvalD & ~iFVAL;
    assign accept = iDVAL & iFVAL & (iH_Cont > 13'(H_MIN)) & (iH_Cont < 13'(H_MAX)) & (iGRAY < 10'(THRESH));
    assign oBUSY  = (state == DIV_X) || (state == DIV_Y);

    // One restoring step per cycle: shift in the next dividend MSB, subtract if it fits.
    assign lastIter = iter == IT_W'(SUM_W - 1);
    assign remShift = {rem, (state == DIV_Y) ? divY[SUM_W-1] : divX[SUM_W-1]};
    assign qBit     = remShift >= {1'b0, divisor};
    assign remNext  = qBit ? CNT_W'(remShift - {1'b0, divisor}) : remShift[CNT_W-1:0];

    always_comb begin
        nextState = state;
        if (state == IDLE)
            nextState = eof ? ((cnt != '0) ? DIV_X : DONE) : IDLE;
        else if (state == DONE)
            nextState = IDLE;
        else if (lastIter)
            nextState = (state == DIV_X) ? DIV_Y : DONE;
    end

    always_ff @(posedge iCLK) begin
        if (iRST)
            state <= IDLE;
        else
            state <= nextState;
    end

    // Accumulation keeps running for the next frame while the divider works.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            fvalD <= 1'b0;
            sumX  <= '0;
            sumY  <= '0;
            cnt   <= '0;
        end else begin
            fvalD <= iFVAL;
            if (eof) begin
                sumX <= '0;
                sumY <= '0;
                cnt  <= '0;
            end else if (accept) begin
                sumX <= sumX + SUM_W'(iH_Cont);
                sumY <= sumY + SUM_W'(iV_Cont);
                cnt  <= cnt + CNT_W'(cnt != '1);
            end
        end
    end

    // divX/divY hold the dividend and collect the quotient bits as they shift out.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            divX    <= '0;
            divY    <= '0;
            divisor <= '0;
            rem     <= '0;
            iter    <= '0;
            oX      <= '0;
            oY      <= '0;
            oCOUNT  <= '0;
            oFOUND  <= 1'b0;
            oVALID  <= 1'b0;
            oDROP   <= 1'b0;
        end else begin
            oVALID <= state == DONE;
            oDROP  <= eof && (state != IDLE);
            if (state == IDLE && eof) begin
                divX    <= sumX;
                divY    <= sumY;
                divisor <= cnt;
                rem     <= '0;
                iter    <= '0;
            end else if (oBUSY) begin
                rem  <= lastIter ? '0 : remNext;
                iter <= lastIter ? '0 : iter + 1'b1;
                if (state == DIV_X)
                    divX <= {divX[SUM_W-2:0], qBit};
                else
                    divY <= {divY[SUM_W-2:0], qBit};
            end
            if (state == DONE) begin
                oCOUNT <= divisor;
                oFOUND <= divisor != '0;
                if (divisor != '0) begin
                    oX <= divX[12:0];
                    oY <= divY[12:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_pupil_locator.sv
// tb_pupil_locator: scoreboard bench; a frame-level centroid model predicts each
// result and drop, and a monitor checks them when the DUT presents them.
module tb_pupil_locator;
    localparam int S = 35;

    logic        iCLK = 1'b0;
    logic        iRST, iDVAL, iFVAL;
    logic [9:0]  iGRAY;
    logic [12:0] iH_Cont, iV_Cont, oX, oY;
    logic [21:0] oCOUNT;
    logic        oFOUND, oVALID, oBUSY, oDROP;

    pupil_locator dut (
        .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL), .iFVAL(iFVAL), .iGRAY(iGRAY),
        .iH_Cont(iH_Cont), .iV_Cont(iV_Cont), .oX(oX), .oY(oY), .oCOUNT(oCOUNT),
        .oFOUND(oFOUND), .oVALID(oVALID), .oBUSY(oBUSY), .oDROP(oDROP)
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    typedef struct {int at; int x; int y; int c; bit f;} exp_t;
    exp_t sbQ[$];
    int   dropQ[$];
    exp_t mt;

    int     total = 0, bad = 0;
    longint sx = 0, sy = 0;
    int     c = 0, lastX = 0, lastY = 0, freeAt = 0, e;

    task automatic chk(string n, longint a, longint x);
        total++;
        if (a != x) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, a, x, cyc);
        end
    endtask

    task automatic pix(bit dv, bit fv, int g, int h, int v);
        iDVAL = dv; iFVAL = fv; iGRAY = 10'(g); iH_Cont = 13'(h); iV_Cont = 13'(v);
        if (dv && fv && h > 255 && h < 640 && g < 200) begin
            sx += h; sy += v; c++;
        end
        @(posedge iCLK); #1;
    endtask

    task automatic idle(int n);
        repeat (n) pix(0, 0, 0, 0, 0);
    endtask

    // A frame is accepted only if the previous result has fully drained back to idle.
    task automatic endFrame(output int e0);
        exp_t t;
        iDVAL = 0; iFVAL = 0;
        e0 = cyc + 1;
        if (e0 < freeAt) dropQ.push_back(e0);
        else begin
            if (c != 0) begin
                t.x = int'(sx / c); t.y = int'(sy / c);
                lastX = t.x; lastY = t.y;
                t.at = e0 + 2 * S + 1; freeAt = e0 + 2 * S + 2;
            end else begin
                t.x = lastX; t.y = lastY;
                t.at = e0 + 1; freeAt = e0 + 2;
            end
            t.c = c; t.f = c != 0;
            sbQ.push_back(t);
        end
        sx = 0; sy = 0; c = 0;
        @(posedge iCLK); #1;
    endtask

    task automatic chkZero(string n);
        chk({n, "_x"}, oX, 0); chk({n, "_y"}, oY, 0); chk({n, "_count"}, oCOUNT, 0);
        chk({n, "_found"}, oFOUND, 0); chk({n, "_valid"}, oVALID, 0);
        chk({n, "_busy"}, oBUSY, 0); chk({n, "_drop"}, oDROP, 0);
    endtask

    always @(negedge iCLK) begin
        if (!iRST) begin
            if (oVALID) begin
                chk("valid_expected", sbQ.size() > 0, 1);
                if (sbQ.size() > 0) begin
                    mt = sbQ.pop_front();
                    chk("valid_cycle", cyc, mt.at);
                    chk("x", oX, mt.x);
                    chk("y", oY, mt.y);
                    chk("count", oCOUNT, mt.c);
                    chk("found", oFOUND, mt.f);
                    chk("busy_at_valid", oBUSY, 0);
                end
            end
            if (oDROP) begin
                chk("drop_expected", dropQ.size() > 0, 1);
                if (dropQ.size() > 0) chk("drop_cycle", cyc, dropQ.pop_front());
            end
        end
    end

    initial begin
        iRST = 1; iDVAL = 0; iFVAL = 0; iGRAY = 0; iH_Cont = 0; iV_Cont = 0;
        repeat (3) @(posedge iCLK);
        #1;
        chkZero("reset");
        iRST = 0;
        idle(2);

        pix(1, 1, 50, 300, 100);
        endFrame(e);
        chk("busy_after_eof", oBUSY, 1);
        idle(80);

        pix(1, 1, 50, 300, 100); pix(0, 1, 0, 301, 100); pix(1, 1, 50, 302, 100);
        pix(1, 1, 50, 300, 104); pix(1, 1, 50, 303, 104);
        endFrame(e); idle(80);

        pix(1, 1, 50, 255, 10); pix(1, 1, 50, 640, 10); pix(1, 1, 200, 400, 50);
        pix(1, 1, 1023, 400, 60);
        endFrame(e); idle(5);
        for (int i = 0; i < 20; i++) pix(1, 1, 1023, 256 + i * 10, i);
        endFrame(e); idle(5);

        pix(1, 0, 50, 300, 100); pix(0, 1, 50, 300, 100); pix(1, 1, 50, 260, 10);
        pix(0, 1, 10, 400, 400); pix(1, 1, 50, 638, 20);
        endFrame(e); idle(80);

        pix(1, 1, 50, 300, 100);
        endFrame(e);
        idle(28);
        pix(1, 1, 50, 500, 500);
        endFrame(e);
        idle(60);
        pix(1, 1, 40, 400, 200); pix(1, 1, 40, 402, 202);
        endFrame(e); idle(80);

        pix(1, 1, 50, 300, 100);
        endFrame(e);
        idle(39);
        iRST = 1;
        @(posedge iCLK); #1;
        iRST = 0;
        sbQ.delete(); freeAt = 0; lastX = 0; lastY = 0;
        chkZero("midreset");
        idle(80);
        pix(1, 1, 50, 500, 300);
        endFrame(e); idle(80);

        for (int f = 0; f < 25; f++) begin
            int n = int'($urandom_range(1, 40));
            for (int k = 0; k < n; k++) begin
                int h = ($urandom % 4 == 0) ? int'($urandom_range(0, 5)) + (($urandom % 2 == 0) ? 253 : 637)
                                            : int'($urandom_range(200, 700));
                int g = ($urandom % 2 == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 1023));
                pix($urandom % 8 != 0, 1, g, h, int'($urandom_range(0, 8191)));
            end
            endFrame(e);
            idle(($urandom % 5 == 0) ? int'($urandom_range(5, 40)) : int'($urandom_range(72, 90)));
        end

        for (int w = 0; w < 200 && (sbQ.size() != 0 || dropQ.size() != 0); w++) idle(1);
        chk("scoreboard_drained", sbQ.size(), 0);
        chk("drops_drained", dropQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
